softstop_xu1_xstepdown_xsoftstop: RTL and testbench
===================================================

# softstop_XU1_XSTEPDOWN_XSOFTSTOP

Soft-stop ramp sequencer for the step-down converter: the ramp-down counterpart of the soft-start reference path. It tracks the soft-start DAC code while the converter is enabled. On disable it walks the reference code down to zero at a controlled slew, then holds the output discharge switch on for a guaranteed minimum time and reports completion. It sits between the soft-start block and the reference DAC mux inside the XSTEPDOWN hierarchy.

## Interface
Parameters:
- WIDTH, 8, reference DAC code width in bits
- STEP_DIV, 16, clock cycles per 1-LSB decrement during ramp-down (≥1)
- DIS_CYCLES, 64, minimum clock cycles the discharge output stays asserted after the ramp reaches zero (≥1)

Ports:
- clk  input  1  block clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- CELV  input  1  supply pin, pass-through only, no logic function
- CELG  input  1  ground pin, pass-through only, no logic function
- SUB  input  1  substrate pin, pass-through only, no logic function
- en  input  1  converter enable from the soft-start block; level sensitive
- code_in  input  WIDTH  current soft-start DAC code
- code  output  WIDTH  reference code to the DAC mux
- busy  output  1  high in RAMPDN or DISCH
- dis  output  1  output discharge switch enable
- done  output  1  one-cycle pulse when the discharge interval ends

## Operation
- Reset value of every output and register:
  - state IDLE, code 0, dis 1, busy 0, done 0
  - prescaler 0, discharge counter 0
- IDLE: code 0, dis 1. en=1 → TRACK.
- TRACK: code <= code_in every cycle; dis 0.
  - en=0 → RAMPDN with code held at its current value, not reloaded from code_in.
  - The prescaler clears on entry to RAMPDN.
- RAMPDN: busy 1, dis 0.
  - If code==0 → DISCH on the next edge, with no tick wait.
  - Otherwise the prescaler counts 0..STEP_DIV-1. At terminal count, code <= code-1 and the prescaler returns to 0.
  - code never underflows.
  - en=1 → TRACK next edge (abort). code resumes following code_in from that edge on. This takes priority over a decrement.
- DISCH: busy 1, dis 1, code 0. The discharge counter clears on entry and counts DIS_CYCLES cycles.
  - On the last count, done=1 for exactly one cycle and state → IDLE.
  - en is ignored in DISCH, so the minimum discharge time is always honoured.
  - en=1 already present on arrival in IDLE → TRACK on the following edge.
- Arithmetic: code is unsigned WIDTH bits. Decrement only when code≠0. The prescaler and discharge counter are sized with $clog2 of their parameter, with a minimum of 1 bit.
- rst=1 at any edge, in any state, forces the reset values above on that edge. A ramp or discharge in progress is abandoned and no done pulse is generated.

## Timing
- TRACK latency: code equals code_in one clock after sampling.
- en sampled 0 at edge t (state TRACK) → RAMPDN from t. First decrement at edge t+STEP_DIV.
- From code N at RAMPDN entry:
  - code reaches 0 at t+N·STEP_DIV.
  - DISCH entered at t+N·STEP_DIV+1.
  - done pulses during the DIS_CYCLES-th DISCH cycle, then IDLE.
- N=0 at RAMPDN entry → DISCH at t+1.
- Outputs are registered or decoded from registered state only. No combinational path from en or code_in to any output.

## Test plan
All scenarios use WIDTH=8, STEP_DIV=4, DIS_CYCLES=8.
- Reset: rst held high 3 cycles with en=1 and code_in=0x55 → code=0, dis=1, busy=0, done=0 throughout; TRACK reached 1 cycle after rst drops.
- Track then stop: en=1 with code_in stepping 0x10→0xC8; en=0 at t → code holds 0xC8, reads 0xC7 at t+4 and 0x00 at t+800; DISCH at t+801 (dis=1); done single pulse 8 cycles later; IDLE after.
- Abort: en=0 with code 0x20; en=1 after 10 cycles (code=0x1E) with code_in=0x40 → TRACK next edge; code=0x40 one cycle later; dis stays 0; done never pulses.
- Zero entry: code_in=0, en 1→0 → DISCH one cycle after RAMPDN entry; done 8 cycles later.
- en during DISCH: en=1 on DISCH cycle 2 → dis held for the full 8 cycles, done pulses, IDLE for one cycle, then TRACK.
- Mid-ramp reset: rst=1 at code 0x33 in RAMPDN → next cycle code=0, dis=1, busy=0; no done pulse.

Source files
------------

// File: rtl/softstop_xu1_xstepdown_xsoftstop.sv
// ----------------------------------------------------------------------------
// softstop_xu1_xstepdown_xsoftstop
//
// Soft-stop ramp sequencer for the step-down converter. While enabled it
// follows the soft-start DAC code. On disable it walks the reference code down
// to zero at one LSB per STEP_DIV clocks. It then holds the output discharge
// switch on for DIS_CYCLES clocks and pulses done.
//
// Ports:
//   clk      block clock, all state updates on the rising edge
//   rst      synchronous, active-high reset
//   CELV     supply pin, pass-through only
//   CELG     ground pin, pass-through only
//   SUB      substrate pin, pass-through only
//   en       converter enable from soft-start (level sensitive)
//   code_in  current soft-start DAC code
//   code     reference code to the DAC mux (registered)
//   busy     high while ramping down or discharging
//   dis      output discharge switch enable
//   done     one-cycle pulse in the last discharge cycle
// ----------------------------------------------------------------------------
module softstop_xu1_xstepdown_xsoftstop #(
  parameter int WIDTH      = 8,
  parameter int STEP_DIV   = 16,
  parameter int DIS_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic             en,
  input  logic [WIDTH-1:0] code_in,
  output logic [WIDTH-1:0] code,
  output logic             busy,
  output logic             dis,
  output logic             done
);

  localparam int PW = (STEP_DIV   > 1) ? $clog2(STEP_DIV)   : 1;
  localparam int DW = (DIS_CYCLES > 1) ? $clog2(DIS_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DCNT_LAST  = DW'(DIS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_RAMPDN = 2'd2,
    S_DISCH  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] code_q,  code_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DW-1:0]    dcnt_q,  dcnt_d;

  // The supply, ground and substrate pins carry no logic; they are only
  // gathered here so they read as intentionally unconnected.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; the reset is synchronous, so it only acts on an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      presc_q <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      presc_q <= presc_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    presc_d = presc_q;
    dcnt_d  = dcnt_q;

    unique case (state_q)
      S_IDLE: begin
        code_d  = '0;
        presc_d = '0;
        dcnt_d  = '0;
        if (en) state_d = S_TRACK;
      end

      S_TRACK: begin
        if (en) begin
          code_d = code_in;
        end else begin
          // Keep the last tracked code; the ramp starts from it.
          state_d = S_RAMPDN;
          presc_d = '0;
        end
      end

      S_RAMPDN: begin
        if (en) begin
          // Re-enable aborts the ramp and wins over a pending decrement.
          state_d = S_TRACK;
          code_d  = code_in;
        end else if (code_q == '0) begin
          state_d = S_DISCH;
          dcnt_d  = '0;
        end else if (presc_q == PRESC_LAST) begin
          code_d  = code_q - WIDTH'(1);
          presc_d = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      S_DISCH: begin
        // en is deliberately ignored so the minimum discharge time holds.
        code_d = '0;
        if (dcnt_q == DCNT_LAST) begin
          state_d = S_IDLE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        code_d  = '0;
        presc_d = '0;
        dcnt_d  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  always_comb begin
    code = code_q;
    busy = (state_q == S_RAMPDN) || (state_q == S_DISCH);
    dis  = (state_q == S_IDLE)   || (state_q == S_DISCH);
    done = (state_q == S_DISCH)  && (dcnt_q == DCNT_LAST);
  end

endmodule

// File: tb/tb_softstop_xu1_xstepdown_xsoftstop.sv
// ----------------------------------------------------------------------------
// tb_softstop_xu1_xstepdown_xsoftstop
//
// Self-checking bench for the soft-stop sequencer with WIDTH=8, STEP_DIV=4,
// DIS_CYCLES=8. A directed vector table comes first, then hand-written
// multi-cycle sequences, then randomized stimulus. A behavioural model tracks
// phase and elapsed cycles and derives the code arithmetically.
// ----------------------------------------------------------------------------
module tb_softstop_xu1_xstepdown_xsoftstop;

  localparam int WIDTH      = 8;
  localparam int STEP_DIV   = 4;
  localparam int DIS_CYCLES = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] code_in;
  logic [WIDTH-1:0] code;
  logic             busy, dis, done;

  int checks = 0;
  int errors = 0;

  softstop_xu1_xstepdown_xsoftstop #(
    .WIDTH     (WIDTH),
    .STEP_DIV  (STEP_DIV),
    .DIS_CYCLES(DIS_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .CELV   (1'b1),
    .CELG   (1'b0),
    .SUB    (1'b0),
    .en     (en),
    .code_in(code_in),
    .code   (code),
    .busy   (busy),
    .dis    (dis),
    .done   (done)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural model: phase plus cycles elapsed in that phase
  // --------------------------------------------------------------------------
  typedef enum int {M_OFF, M_FOLLOW, M_SLEW, M_DRAIN} mphase_e;

  mphase_e m_ph    = M_OFF;
  int      m_code  = 0;
  int      m_start = 0;
  int      m_age   = 0;

  task automatic model_step(input logic r, input logic e, input logic [7:0] ci);
    if (r) begin
      m_ph   = M_OFF;
      m_code = 0;
      m_age  = 0;
    end else begin
      case (m_ph)
        M_OFF: begin
          m_code = 0;
          if (e) m_ph = M_FOLLOW;
        end
        M_FOLLOW: begin
          if (e) m_code = int'(ci);
          else begin
            m_ph    = M_SLEW;
            m_start = m_code;
            m_age   = 0;
          end
        end
        M_SLEW: begin
          if (e) begin
            m_ph   = M_FOLLOW;
            m_code = int'(ci);
          end else if (m_code == 0) begin
            m_ph  = M_DRAIN;
            m_age = 0;
          end else begin
            m_age++;
            m_code = (m_age / STEP_DIV >= m_start) ? 0 : m_start - m_age / STEP_DIV;
          end
        end
        default: begin
          m_code = 0;
          m_age++;
          if (m_age == DIS_CYCLES) m_ph = M_OFF;
        end
      endcase
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model_code", int'(code), m_code);
    check("model_dis",  int'(dis),  int'(m_ph == M_OFF || m_ph == M_DRAIN));
    check("model_busy", int'(busy), int'(m_ph == M_SLEW || m_ph == M_DRAIN));
    check("model_done", int'(done), int'(m_ph == M_DRAIN && m_age == DIS_CYCLES - 1));
  endtask

  // Drive inputs, take one edge, sample #1 later, advance model and compare.
  task automatic step(input logic r, input logic e, input logic [7:0] ci);
    rst = r; en = e; code_in = ci;
    @(posedge clk); #1;
    model_step(r, e, ci);
    cmp_model();
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] code_in;
    logic [7:0] e_code;
    logic       e_dis;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic [7:0] ci,
                              input logic [7:0] ec, input logic ed,
                              input logic eb, input logic edn);
    vec_t v;
    v.rst = r; v.en = e; v.code_in = ci;
    v.e_code = ec; v.e_dis = ed; v.e_busy = eb; v.e_done = edn;
    vecs.push_back(v);
  endfunction

  initial begin
    int ndone;
    int first_done;
    int dis_low;
    logic r_en;

    rst = 1'b1; en = 1'b0; code_in = '0;

    // Reset held with en=1, then track, ramp, abort, zero entry, discharge.
    for (int i = 0; i < 3; i++) add(1, 1, 8'h55, 8'h00, 1, 0, 0);
    add(0, 1, 8'h55, 8'h00, 0, 0, 0);            // TRACK one cycle after reset
    add(0, 1, 8'h10, 8'h10, 0, 0, 0);
    add(0, 1, 8'h03, 8'h03, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 8'h77, 8'h03, 0, 1, 0);  // held code
    add(0, 0, 8'h77, 8'h02, 0, 1, 0);            // first decrement after 4 edges
    add(0, 1, 8'h22, 8'h22, 0, 0, 0);            // abort reloads code_in
    add(0, 0, 8'h22, 8'h22, 0, 1, 0);
    add(0, 1, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 1, 0);            // RAMPDN with code 0
    add(0, 0, 8'h00, 8'h00, 1, 1, 0);            // DISCH next edge
    for (int i = 0; i < 6; i++) add(0, 0, 8'h00, 8'h00, 1, 1, 0);
    add(0, 0, 8'h00, 8'h00, 1, 1, 1);            // 8th DISCH cycle: done
    add(0, 0, 8'h00, 8'h00, 1, 0, 0);            // IDLE
    add(0, 1, 8'h44, 8'h00, 0, 0, 0);            // TRACK, code still 0
    add(1, 1, 8'h44, 8'h00, 1, 0, 0);            // reset out of TRACK

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en = vecs[i].en; code_in = vecs[i].code_in;
      @(posedge clk); #1;
      model_step(vecs[i].rst, vecs[i].en, vecs[i].code_in);
      check($sformatf("vec%0d_code", i), int'(code), int'(vecs[i].e_code));
      check($sformatf("vec%0d_dis",  i), int'(dis),  int'(vecs[i].e_dis));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
    end

    // ---- Track then stop from 0xC8 ----
    for (int v = 8'h10; v <= 8'hC8; v += 8) step(0, 1, 8'(v));
    step(0, 1, 8'hC8);
    check("stop_pre_code", int'(code), 8'hC8);
    step(0, 0, 8'h3C);                           // edge t
    check("stop_t_hold", int'(code), 8'hC8);
    check("stop_t_busy", int'(busy), 1);
    ndone = 0; first_done = -1;
    for (int k = 1; k <= 815; k++) begin
      step(0, 0, 8'h3C);
      if (k == 3)   check("stop_t3_code", int'(code), 8'hC8);
      if (k == 4)   check("stop_t4_code", int'(code), 8'hC7);
      if (k == 799) check("stop_t799_code", int'(code), 8'h01);
      if (k == 800) begin
        check("stop_t800_code", int'(code), 8'h00);
        check("stop_t800_dis", int'(dis), 0);
      end
      if (k == 801) begin
        check("stop_t801_dis", int'(dis), 1);
        check("stop_t801_busy", int'(busy), 1);
      end
      if (k == 809) begin
        check("stop_idle_busy", int'(busy), 0);
        check("stop_idle_dis", int'(dis), 1);
      end
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
    end
    check("stop_done_count", ndone, 1);
    check("stop_done_time", first_done, 808);

    // ---- Abort mid-ramp ----
    step(0, 1, 8'h20);
    step(0, 1, 8'h20);
    step(0, 0, 8'h20);                           // edge t
    for (int k = 1; k <= 10; k++) step(0, 0, 8'h20);
    check("abort_pre_code", int'(code), 8'h1E);
    step(0, 1, 8'h40);
    check("abort_code", int'(code), 8'h40);
    check("abort_busy", int'(busy), 0);
    ndone = 0; dis_low = 1;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 8'h40);
      if (done) ndone++;
      if (dis) dis_low = 0;
    end
    check("abort_no_done", ndone, 0);
    check("abort_dis_low", dis_low, 1);

    // ---- Zero code at ramp entry ----
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);                           // edge t
    check("zero_t_busy", int'(busy), 1);
    check("zero_t_dis", int'(dis), 0);
    step(0, 0, 8'h00);
    check("zero_t1_dis", int'(dis), 1);
    ndone = 0; first_done = -1;
    for (int k = 2; k <= 9; k++) begin
      step(0, 0, 8'h00);
      if (done) begin ndone++; first_done = k; end
    end
    check("zero_done_count", ndone, 1);
    check("zero_done_time", first_done, 8);
    check("zero_idle_busy", int'(busy), 0);

    // ---- en raised during discharge ----
    step(0, 1, 8'h05);
    step(0, 1, 8'h05);
    step(0, 0, 8'h05);                           // edge t
    for (int k = 1; k <= 20; k++) step(0, 0, 8'h05);
    check("disen_t20_code", int'(code), 0);
    step(0, 0, 8'h05);
    check("disen_t21_dis", int'(dis), 1);
    step(0, 0, 8'h05);
    ndone = 0; dis_low = 0;
    for (int j = 0; j < 6; j++) begin
      step(0, 1, 8'h05);
      if (!dis) dis_low = 1;
      if (done) ndone++;
    end
    check("disen_dis_held", dis_low, 0);
    check("disen_done_count", ndone, 1);
    step(0, 1, 8'h05);
    check("disen_idle_busy", int'(busy), 0);
    check("disen_idle_dis", int'(dis), 1);
    step(0, 1, 8'h05);
    check("disen_track_dis", int'(dis), 0);
    step(0, 1, 8'h05);
    check("disen_track_code", int'(code), 8'h05);

    // ---- Reset in the middle of a ramp ----
    step(0, 1, 8'h40);
    step(0, 0, 8'h40);                           // edge t
    for (int k = 1; k <= 52; k++) step(0, 0, 8'h40);
    check("rst_pre_code", int'(code), 8'h33);
    step(1, 0, 8'h00);
    check("rst_code", int'(code), 0);
    check("rst_dis", int'(dis), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 8'h00);
      if (done) ndone++;
    end
    check("rst_no_done", ndone, 0);

    // ---- Randomized stimulus against the model ----
    r_en = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 24) == 0) r_en = ~r_en;
      step(($urandom_range(0, 399) == 0), r_en, 8'($urandom_range(0, 24)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
